conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Downstream consumer of the pixel FIFO.
- Pops pixels in raster order via the FIFO's ren/empty interface and buffers the previous two image rows in line buffers.
- Emits every valid 3x3 convolution window, unpadded with stride 1, on a valid/ready bus to the MAC array.
- Frame boundaries are controlled by a start pulse and reported by a done pulse.

Parameters:
- WIDTH, 8: pixel width in bits.
- IMG_W, 28: image width in pixels; must be ≥ 3.
- IMG_H, 28: image height in pixels; must be ≥ 3.
- CNT_BIT, 5: width of the row/column counters; 2^CNT_BIT ≥ max(IMG_W, IMG_H).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a frame; ignored unless in IDLE.
- fifo_empty  in  1  FIFO empty flag.
- fifo_ren  out  1  FIFO read enable.
- fifo_dout  in  WIDTH  FIFO data; valid the cycle after a ren that hit a non-empty FIFO.
- win_valid  out  1  window valid.
- win_ready  in  1  downstream ready.
- win_data  out  9*WIDTH  window, row-major; [WIDTH-1:0] = top-left, [9*WIDTH-1:8*WIDTH] = bottom-right (newest pixel).
- busy  out  1  high in RUN and DRAIN.
- frame_done  out  1  one-cycle pulse after the last window of a frame is accepted.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, skid buffer empty, line buffers and window registers 0.
- States:
  - IDLE → RUN on start.
  - RUN → DRAIN when the IMG_W*IMG_H-th pixel has been read (ren issued).
  - DRAIN → DONE when no read data is in flight, the skid buffer is empty, and win_valid is 0.
  - DONE → IDLE unconditionally; frame_done=1 for exactly this cycle.
- fifo_ren = (state==RUN) && !fifo_empty && !pix_pending_stall.
  - pix_pending_stall = skid buffer full, or (win_valid && !win_ready).
  - fifo_ren is never asserted in IDLE, DRAIN or DONE.
  - No more than IMG_W*IMG_H reads are issued per frame.
- Read latency is 1 cycle. A flag registered from fifo_ren marks fifo_dout as a valid pixel on the next cycle.
- If the window stage is stalled when the pixel arrives, the pixel is captured in a 1-entry skid buffer. No pixel is ever dropped or duplicated.
- On each accepted pixel p at (row r, col c):
  - Shift the column {linebuf1[c], linebuf0[c], p} into the 3x3 register window.
  - Write linebuf1[c] ← linebuf0[c] and linebuf0[c] ← p.
  - Advance c; wrap to 0 at IMG_W-1 and increment r.
- A window is produced for pixel (r, c) iff r ≥ 2 and c ≥ 2. Windows spanning the row wrap (c = 0, 1) are suppressed.
- Windows per frame: (IMG_W-2)*(IMG_H-2).
- win_valid is asserted 1 cycle after the qualifying pixel is accepted.
- win_valid/win_data hold stable while win_valid && !win_ready.
- Transfer occurs on win_valid && win_ready.
- Throughput: 1 window/cycle when the FIFO is non-empty and win_ready is 1.
- FIFO empty mid-frame: no ren; window stage holds; resumes on the next non-empty cycle.
- start while busy: ignored.
- rst mid-frame: immediate return to IDLE with all outputs 0. A pixel returned by an in-flight read is discarded.
- Line buffer contents are not cleared between frames. No window ever uses stale rows, because rows 0–1 of each frame are never emitted.

Optional Feature:
- Macro: CONV_WINDOW_GEN_COORD_EN.
- Defined:
  - Extra outputs win_row and win_col, each CNT_BIT wide, out of the module.
  - They give the image coordinate of the window centre (r-1, c-1).
  - Registered alongside win_data; same valid/hold rules; reset 0.
- Undefined: the ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- IMG_W=4, IMG_H=4; FIFO preloaded with 0..15; win_ready=1; start → fifo_ren high 16 cycles, 4 windows:
  - {0,1,2,4,5,6,8,9,10}
  - {1,2,3,5,6,7,9,10,11}
  - {4,5,6,8,9,10,12,13,14}
  - {5,6,7,9,10,11,13,14,15}
  - then one frame_done pulse; busy low afterwards.
- Same frame with win_ready toggling 1,0,0,1 repeatedly → identical 4 windows in order; win_data stable during stalls; no ren issued while the skid buffer is full.
- FIFO starved (one pixel pushed every 5 cycles) → same 4 windows; fifo_ren never asserted while fifo_empty=1.
- rst pulsed after pixel 9 → outputs 0, state IDLE. A new start with pixels 100..115 → first window {100,101,102,104,105,106,108,109,110}.
- start pulsed while busy → ignored; exactly 4 windows and 1 frame_done.
- Two back-to-back frames (0..15, then 16..31) → 8 windows total; second-frame first window {16,17,18,20,21,22,24,25,26}. With CONV_WINDOW_GEN_COORD_EN, (row, col) = (1,1), (1,2), (2,1), (2,2).

Source files
------------

// File: rtl/conv_window_gen.sv
// conv_window_gen
// Pops pixels in raster order from the pixel FIFO, keeps the previous two
// image rows in line buffers and emits every valid 3x3 window (unpadded,
// stride 1) on a valid/ready bus towards the MAC array.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             one-cycle pulse, begins a frame (only honoured in IDLE)
//   fifo_empty/ren    FIFO handshake; fifo_dout valid the cycle after a read
//   win_valid/ready   window handshake; win_data is row-major, [WIDTH-1:0] is
//                     the top-left pixel, the top slice is the newest pixel
//   busy              high while a frame is being read or drained
//   frame_done        one-cycle pulse once the last window has been taken
//
// Optional build macro CONV_WINDOW_GEN_COORD_EN adds win_row/win_col, the
// image coordinate of the window centre, held alongside win_data.

module conv_window_gen #(
   parameter int WIDTH   = 8,
   parameter int IMG_W   = 28,
   parameter int IMG_H   = 28,
   parameter int CNT_BIT = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 fifo_empty,
   output logic                 fifo_ren,
   input  logic [WIDTH-1:0]     fifo_dout,
   output logic                 win_valid,
   input  logic                 win_ready,
   output logic [9*WIDTH-1:0]   win_data,
   output logic                 busy,
   output logic                 frame_done
`ifdef CONV_WINDOW_GEN_COORD_EN
   ,
   output logic [CNT_BIT-1:0]   win_row,
   output logic [CNT_BIT-1:0]   win_col
`endif
);

   localparam int TOTAL  = IMG_W * IMG_H;
   // One spare bit so the read counter can hold any IMG_W*IMG_H allowed by CNT_BIT.
   localparam int RCNT_W = 2 * CNT_BIT + 1;
   localparam int AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   localparam logic [CNT_BIT-1:0] ONE      = CNT_BIT'(1);
   localparam logic [CNT_BIT-1:0] TWO      = CNT_BIT'(2);
   localparam logic [CNT_BIT-1:0] LAST_COL = CNT_BIT'(IMG_W - 1);
   localparam logic [CNT_BIT-1:0] LAST_ROW = CNT_BIT'(IMG_H - 1);
   localparam logic [RCNT_W-1:0]  LAST_RD  = RCNT_W'(TOTAL - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t              state, state_nxt;
   logic [RCNT_W-1:0]   rd_count;
   logic                rd_valid;
   logic                skid_full;
   logic [WIDTH-1:0]    skid_data;
   logic [CNT_BIT-1:0]  col, row;
   logic [AW-1:0]       col_idx;
   logic [WIDTH-1:0]    linebuf0 [IMG_W];
   logic [WIDTH-1:0]    linebuf1 [IMG_W];
   logic [WIDTH-1:0]    win [9];

   logic                out_stall;
   logic                accept;
   logic                emit;
   logic                frame_start;
   logic [WIDTH-1:0]    pix;

   // The skid buffer always holds the oldest pixel, so it is consumed first.
   assign out_stall   = win_valid && !win_ready;
   assign pix         = skid_full ? skid_data : fifo_dout;
   assign accept      = (skid_full || rd_valid) && !out_stall;
   assign emit        = accept && (row >= TWO) && (col >= TWO);
   assign frame_start = (state == IDLE) && start;
   assign col_idx     = col[AW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Reads stop as soon as the last pixel of the frame has been requested;
   // DRAIN then waits for that pixel to work its way out as a window.
   always_comb begin
      state_nxt  = state;
      fifo_ren   = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy     = 1'b1;
            fifo_ren = !fifo_empty && !(skid_full || out_stall);
            if (fifo_ren && (rd_count == LAST_RD)) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (!rd_valid && !skid_full && !win_valid) state_nxt = DONE;
         end
         DONE: begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_count <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= fifo_ren;
         if (frame_start)   rd_count <= '0;
         else if (fifo_ren) rd_count <= rd_count + RCNT_W'(1);
      end
   end

   // A returning pixel parks in the skid buffer whenever the window stage
   // cannot take it, or when an older parked pixel is being taken instead.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_full <= 1'b0;
         skid_data <= '0;
      end else if (rd_valid && (skid_full || out_stall)) begin
         skid_full <= 1'b1;
         skid_data <= fifo_dout;
      end else if (accept) begin
         skid_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (frame_start) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col == LAST_COL) begin
            col <= '0;
            row <= (row == LAST_ROW) ? '0 : row + ONE;
         end else begin
            col <= col + ONE;
         end
      end
   end

   // Window is row-major: index 0..2 top row (oldest line), 6..8 bottom row.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < IMG_W; i++) begin
            linebuf0[i] <= '0;
            linebuf1[i] <= '0;
         end
         for (int k = 0; k < 9; k++) win[k] <= '0;
      end else if (accept) begin
         linebuf1[col_idx] <= linebuf0[col_idx];
         linebuf0[col_idx] <= pix;
         for (int i = 0; i < 3; i++) begin
            win[i*3]     <= win[i*3 + 1];
            win[i*3 + 1] <= win[i*3 + 2];
         end
         win[2] <= linebuf1[col_idx];
         win[5] <= linebuf0[col_idx];
         win[8] <= pix;
      end
   end

   for (genvar k = 0; k < 9; k++) begin : g_pack
      assign win_data[k*WIDTH +: WIDTH] = win[k];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            win_valid <= 1'b0;
      else if (emit)      win_valid <= 1'b1;
      else if (win_ready) win_valid <= 1'b0;
   end

`ifdef CONV_WINDOW_GEN_COORD_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_row <= '0;
         win_col <= '0;
      end else if (emit) begin
         win_row <= row - ONE;
         win_col <= col - ONE;
      end
   end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen
// Self-checking bench for conv_window_gen on a 4x4 image. A queue-backed FIFO
// model feeds the design; expected windows are derived from each frame's pixel
// array and compared in order against every accepted window.

module tb_conv_window_gen;

   localparam int WIDTH   = 8;
   localparam int IMG_W   = 4;
   localparam int IMG_H   = 4;
   localparam int CNT_BIT = 3;
   localparam int NPIX    = IMG_W * IMG_H;
   localparam int NWIN    = (IMG_W - 2) * (IMG_H - 2);

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic                fifo_empty;
   logic                fifo_ren;
   logic [WIDTH-1:0]    fifo_dout = '0;
   logic                win_valid;
   logic                win_ready = 1'b1;
   logic [9*WIDTH-1:0]  win_data;
   logic                busy;
   logic                frame_done;
`ifdef CONV_WINDOW_GEN_COORD_EN
   logic [CNT_BIT-1:0]  win_row;
   logic [CNT_BIT-1:0]  win_col;
`endif

   conv_window_gen #(
      .WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_BIT(CNT_BIT)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .fifo_empty(fifo_empty), .fifo_ren(fifo_ren), .fifo_dout(fifo_dout),
      .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
      .busy(busy), .frame_done(frame_done)
`ifdef CONV_WINDOW_GEN_COORD_EN
      , .win_row(win_row), .win_col(win_col)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // FIFO model: stimulus writes mem/wr_ptr, the read side pops with one cycle latency.
   logic [WIDTH-1:0] mem [0:1023];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_ren && !fifo_empty) begin
         fifo_dout <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   task automatic pushPixel(input int val);
      mem[wr_ptr] = WIDTH'(val);
      wr_ptr++;
   endtask

   // Downstream ready: 0 always ready, 1 repeating 1,0,0,1, 2 random.
   int ready_mode = 0;
   int phase = 0;
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: win_ready = 1'b1;
         1: begin
            win_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
            phase++;
         end
         default: win_ready = ($urandom_range(0, 1) == 1);
      endcase
   end

   logic [9*WIDTH-1:0] exp_q[$];
   int                 exp_r[$];
   int                 exp_c[$];
   logic [9*WIDTH-1:0] seen_q[$];
   logic [9*WIDTH-1:0] held = '0;
   bit                 stalled_prev = 1'b0;
   int                 reads = 0;
   int                 dones = 0;
   int                 wins  = 0;

   always @(negedge clk) begin
      if (rst) begin
         stalled_prev = 1'b0;
      end else begin
         if (fifo_ren) begin
            reads++;
            checkOutput("ren_while_empty", fifo_empty, 0);
         end
         if (frame_done) dones++;
         if (stalled_prev) begin
            checkOutput("hold_valid", win_valid, 1);
            checkOutput("hold_data", win_data, held);
         end
         if (win_valid && win_ready) begin
            wins++;
            seen_q.push_back(win_data);
            checkOutput("window_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               checkOutput("win_data", win_data, exp_q.pop_front());
`ifdef CONV_WINDOW_GEN_COORD_EN
               checkOutput("win_row", win_row, exp_r.pop_front());
               checkOutput("win_col", win_col, exp_c.pop_front());
`else
               void'(exp_r.pop_front());
               void'(exp_c.pop_front());
`endif
            end
         end
         stalled_prev = win_valid && !win_ready;
         held = win_data;
      end
   end

   // Runs one whole frame: builds the pixels and the windows they imply,
   // feeds the FIFO, pulses start and waits for frame_done.
   task automatic applyStimulus(input int base, input bit rnd, input int mode,
                                input int gap, input bit poke_start);
      int pix [NPIX];
      logic [9*WIDTH-1:0] w;
      int r0, d0, w0;
      for (int i = 0; i < NPIX; i++)
         pix[i] = rnd ? int'($urandom_range(0, 255)) : base + i;
      for (int r = 2; r < IMG_H; r++) begin
         for (int c = 2; c < IMG_W; c++) begin
            for (int k = 0; k < 9; k++)
               w[k*WIDTH +: WIDTH] = WIDTH'(pix[(r - 2 + k / 3) * IMG_W + (c - 2 + k % 3)]);
            exp_q.push_back(w);
            exp_r.push_back(r - 1);
            exp_c.push_back(c - 1);
         end
      end
      seen_q.delete();
      ready_mode = mode;
      phase = 0;
      r0 = reads;
      d0 = dones;
      w0 = wins;
      if (gap == 0) begin
         for (int i = 0; i < NPIX; i++) pushPixel(pix[i]);
         @(negedge clk);
         checkOutput("ren_in_idle", fifo_ren, 0);
      end
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (poke_start) begin
         repeat (6) @(posedge clk);
         #1;
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      if (gap > 0) begin
         for (int i = 0; i < NPIX; i++) begin
            pushPixel(pix[i]);
            repeat (gap) @(posedge clk);
            #1;
         end
      end
      for (int t = 0; t < 4000 && dones == d0; t++) begin
         @(posedge clk); #1;
      end
      repeat (4) @(posedge clk);
      #1;
      checkOutput("frame_done_count", dones - d0, 1);
      checkOutput("reads_per_frame", reads - r0, NPIX);
      checkOutput("windows_per_frame", wins - w0, NWIN);
      checkOutput("all_windows_seen", exp_q.size(), 0);
      checkOutput("busy_after_frame", busy, 0);
      checkOutput("valid_after_frame", win_valid, 0);
   endtask

   function automatic logic [9*WIDTH-1:0] seqWindow(input int base);
      logic [9*WIDTH-1:0] v;
      for (int k = 0; k < 9; k++)
         v[k*WIDTH +: WIDTH] = WIDTH'(base + (k / 3) * IMG_W + (k % 3));
      return v;
   endfunction

   initial begin
      repeat (3) @(negedge clk);
      checkOutput("reset_fifo_ren", fifo_ren, 0);
      checkOutput("reset_win_valid", win_valid, 0);
      checkOutput("reset_win_data", win_data, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_frame_done", frame_done, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      $display("[TB] sequential frame, always ready");
      applyStimulus(0, 1'b0, 0, 0, 1'b0);
      checkOutput("first_window_seq", seen_q.size() != 0, 1);
      if (seen_q.size() != 0) checkOutput("first_window_0", seen_q[0], seqWindow(0));

      $display("[TB] ready pattern 1,0,0,1");
      applyStimulus(0, 1'b0, 1, 0, 1'b0);

      $display("[TB] starved FIFO, one pixel every 5 cycles");
      applyStimulus(0, 1'b0, 0, 5, 1'b0);

      $display("[TB] reset after pixel 9");
      ready_mode = 0;
      for (int i = 0; i < 10; i++) pushPixel(i);
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int t = 0; t < 200 && !fifo_empty; t++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midreset_fifo_ren", fifo_ren, 0);
      checkOutput("midreset_win_valid", win_valid, 0);
      checkOutput("midreset_busy", busy, 0);
      checkOutput("midreset_win_data", win_data, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      applyStimulus(100, 1'b0, 0, 0, 1'b0);
      checkOutput("first_window_seq", seen_q.size() != 0, 1);
      if (seen_q.size() != 0) checkOutput("first_window_100", seen_q[0], seqWindow(100));

      $display("[TB] start pulsed while busy");
      applyStimulus(0, 1'b0, 0, 0, 1'b1);

      $display("[TB] back-to-back frames");
      applyStimulus(0, 1'b0, 0, 0, 1'b0);
      applyStimulus(16, 1'b0, 0, 0, 1'b0);
      checkOutput("first_window_seq", seen_q.size() != 0, 1);
      if (seen_q.size() != 0) checkOutput("first_window_16", seen_q[0], seqWindow(16));

      $display("[TB] random pixels, random ready");
      for (int f = 0; f < 3; f++) applyStimulus(0, 1'b1, 2, 0, 1'b0);
      applyStimulus(0, 1'b1, 2, 3, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
